// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - state encoding localparams and the state enum built from them
//   - default clocks-per-bit for 16.368 MHz / 115200 baud
//   - data width and idle line level
//   - even_parity(): parity helper for the optional parity bit
package uart_pkg;

  localparam int   CLKS_PER_BIT_DEF = 142;
  localparam int   DATA_W           = 8;
  localparam logic LINE_IDLE        = 1'b1;

  // Encodings are fixed so uart_rx can decode the same values.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE       = ST_IDLE,
    START_BIT  = ST_START,
    DATA_BITS  = ST_DATA,
    PARITY_BIT = ST_PARITY,
    STOP_BIT   = ST_STOP,
    DONE       = ST_DONE
  } uart_state_e;

  // Even parity over one data byte.
  function automatic logic even_parity(input logic [DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_cntr.sv
// uart_baud_cntr: bit-period counter with two selectable terminal counts.
//   clk_in, rst_in_n : clock, asynchronous active-low reset
//   clear            : synchronous clear back to zero
//   limit_sel        : 1 = full bit (CLKS_PER_BIT cycles), 0 = ALT_CLKS cycles
//   tc               : high on the last cycle of the selected period
// The counter wraps to zero on tc, so consecutive periods need no clear.
// ALT_CLKS defaults to a half bit for receiver centre-sampling.
module uart_baud_cntr
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int ALT_CLKS     = CLKS_PER_BIT / 2
) (
  input  logic clk_in,
  input  logic rst_in_n,
  input  logic clear,
  input  logic limit_sel,
  output logic tc
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LIM = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] ALT_LIM  = CNT_W'(ALT_CLKS - 1);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] limit_s;

  assign limit_s = limit_sel ? FULL_LIM : ALT_LIM;
  assign tc      = (count_r == limit_s);

  // Cycle counter within the current bit period.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      count_r <= '0;
    end else if (clear || tc) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, 1 start bit, 8 data bits LSB first, STOP_BITS
// stop bits, with a one-byte holding register for back-to-back frames.
//   clk_in, rst_in_n : clock, asynchronous active-low reset
//   tx_dv_in         : byte-valid strobe; accepted when tx_ready_out=1
//   tx_data_in       : byte to send, sampled only on accept
//   tx_ready_out     : holding register empty
//   tx_busy_out      : frame on the line
//   tx_done_out      : one-cycle pulse in the last stop-bit cycle
//   tx_out           : serial line, idles high
// Build option: define UART_TX_PARITY_EN to append an even parity bit
// between the data bits and the stop bits.
// All outputs come straight from flops, so the line trails the FSM state by
// one cycle. DONE is the last cycle of stop time: the final stop bit uses a
// one-cycle-short count so a frame is exactly CLKS_PER_BIT*(9+STOP_BITS).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk_in,
  input  logic              rst_in_n,
  input  logic              tx_dv_in,
  input  logic [DATA_W-1:0] tx_data_in,
  output logic              tx_ready_out,
  output logic              tx_busy_out,
  output logic              tx_done_out,
  output logic              tx_out
);

  uart_state_e       state_r;
  uart_state_e       next_state_s;
  logic              ready_r;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] shift_r;
  logic [2:0]        bit_idx_r;
  logic              tx_r;
  logic              busy_r;
  logic              done_r;
  logic              accept_s;
  logic              load_s;
  logic              clear_s;
  logic              limit_sel_s;
  logic              tc_s;
  logic              stop_last_s;
  logic              line_s;
`ifdef UART_TX_PARITY_EN
  logic              parity_r;
`endif

  assign accept_s    = tx_dv_in && ready_r;
  // With two stop bits, bit_idx wraps to 0 after the data and marks the
  // second stop bit with a 1.
  assign stop_last_s = (STOP_BITS == 1) ? 1'b1 : bit_idx_r[0];
  assign limit_sel_s = !((state_r == STOP_BIT) && stop_last_s);
  assign clear_s     = (next_state_s != state_r) || (state_r == IDLE);

  uart_baud_cntr #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .ALT_CLKS     (CLKS_PER_BIT - 1)
  ) u_baud (
    .clk_in    (clk_in),
    .rst_in_n  (rst_in_n),
    .clear     (clear_s),
    .limit_sel (limit_sel_s),
    .tc        (tc_s)
  );

  // Next-state and shifter-load decode.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (!ready_r) begin
          load_s       = 1'b1;
          next_state_s = START_BIT;
        end else begin
          next_state_s = IDLE;
        end
      end
      START_BIT: begin
        if (tc_s) next_state_s = DATA_BITS;
        else      next_state_s = START_BIT;
      end
      DATA_BITS: begin
        if (tc_s && (bit_idx_r == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          next_state_s = PARITY_BIT;
`else
          next_state_s = STOP_BIT;
`endif
        end else begin
          next_state_s = DATA_BITS;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY_BIT: begin
        if (tc_s) next_state_s = STOP_BIT;
        else      next_state_s = PARITY_BIT;
      end
`endif
      STOP_BIT: begin
        if (tc_s && stop_last_s) next_state_s = DONE;
        else                     next_state_s = STOP_BIT;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Line level implied by the current state.
  always_comb begin
    line_s = LINE_IDLE;
    case (state_r)
      START_BIT: line_s = 1'b0;
      DATA_BITS: line_s = shift_r[0];
`ifdef UART_TX_PARITY_EN
      PARITY_BIT: line_s = parity_r;
`endif
      default:   line_s = LINE_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) state_r <= IDLE;
    else           state_r <= next_state_s;
  end

  // Holding register; a load frees the slot before any new accept fills it.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      ready_r <= 1'b1;
      hold_r  <= '0;
    end else if (accept_s) begin
      ready_r <= 1'b0;
      hold_r  <= tx_data_in;
    end else if (load_s) begin
      ready_r <= 1'b1;
    end else begin
      ready_r <= ready_r;
    end
  end

  // Shift register and bit index (data bits, then stop bits).
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      shift_r   <= '0;
      bit_idx_r <= 3'd0;
    end else if (load_s) begin
      shift_r   <= hold_r;
      bit_idx_r <= 3'd0;
    end else if (tc_s && (state_r == DATA_BITS)) begin
      shift_r   <= {1'b0, shift_r[DATA_W-1:1]};
      bit_idx_r <= bit_idx_r + 3'd1;
    end else if (tc_s && (state_r == STOP_BIT)) begin
      bit_idx_r <= bit_idx_r + 3'd1;
    end else begin
      shift_r   <= shift_r;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity computed once, when the byte enters the shifter.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n)   parity_r <= 1'b0;
    else if (load_s) parity_r <= even_parity(hold_r);
    else             parity_r <= parity_r;
  end
`endif

  // Registered outputs.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      tx_r   <= LINE_IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      tx_r   <= line_s;
      busy_r <= (state_r != IDLE);
      done_r <= (state_r == DONE);
    end
  end

  assign tx_out       = tx_r;
  assign tx_busy_out  = busy_r;
  assign tx_done_out  = done_r;
  assign tx_ready_out = ready_r;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: two transmitters (1 and 2 stop bits) at CLKS_PER_BIT=4, checked
// cycle by cycle against an expected-waveform model built per accepted byte.
// Model rules: an accept at edge N starts a frame at edge
// max(N+2, previous start + frame length); the line carries start, data LSB
// first, optional parity and stop bits for CPB cycles each; done is high in
// the last cycle of the frame; ready is low from the accept until one cycle
// before the frame starts.
module tb_uart_tx;

  localparam int CPB  = 4;
  localparam int MAXC = 16384;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk_in;
  logic       rst_n;
  logic [1:0] dv;
  logic [7:0] din [2];
  logic [1:0] txo, rdy, bsy, dn;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  bit exp_line  [2][MAXC];
  bit exp_busy  [2][MAXC];
  bit exp_done  [2][MAXC];
  bit exp_ready [2][MAXC];
  int last_start [2];
  int pend_acc   [2];
  int pend_load  [2];

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut0 (
    .clk_in(clk_in), .rst_in_n(rst_n), .tx_dv_in(dv[0]), .tx_data_in(din[0]),
    .tx_ready_out(rdy[0]), .tx_busy_out(bsy[0]), .tx_done_out(dn[0]), .tx_out(txo[0]));

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut1 (
    .clk_in(clk_in), .rst_in_n(rst_n), .tx_dv_in(dv[1]), .tx_data_in(din[1]),
    .tx_ready_out(rdy[1]), .tx_busy_out(bsy[1]), .tx_done_out(dn[1]), .tx_out(txo[1]));

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
  endtask

  function automatic int frame_len(input int k);
    return CPB * (9 + PB + k + 1);
  endfunction

  function automatic void clear_model(input int from);
    for (int k = 0; k < 2; k++) begin
      for (int c = from; c < MAXC; c++) begin
        exp_line[k][c] = 1'b1; exp_busy[k][c] = 1'b0;
        exp_done[k][c] = 1'b0; exp_ready[k][c] = 1'b1;
      end
      last_start[k] = -100000; pend_acc[k] = -10; pend_load[k] = -10;
    end
  endfunction

  function automatic void plan_frame(input int k, input int st, input logic [7:0] d);
    bit bits[$];
    int idx;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (PB == 1) bits.push_back(^d);
    for (int i = 0; i <= k; i++) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++)
      for (int j = 0; j < CPB; j++) begin
        idx = st + b * CPB + j;
        if (idx < MAXC) begin exp_line[k][idx] = bits[b]; exp_busy[k][idx] = 1'b1; end
      end
    idx = st + frame_len(k) - 1;
    if (idx < MAXC) exp_done[k][idx] = 1'b1;
  endfunction

  // Called just after a falling edge; drives one strobe over the next edge.
  task automatic send(input int k, input logic [7:0] d);
    int n, st;
    n = cyc + 1;
    if (!(pend_acc[k] < n && n <= pend_load[k])) begin
      st = (n + 2 > last_start[k] + frame_len(k)) ? n + 2 : last_start[k] + frame_len(k);
      plan_frame(k, st, d);
      for (int c = n; c <= st - 2; c++) exp_ready[k][c] = 1'b0;
      pend_acc[k] = n; pend_load[k] = st - 1; last_start[k] = st;
    end
    dv[k] = 1'b1; din[k] = d;
    @(negedge clk_in);
    dv[k] = 1'b0; din[k] = 8'($urandom);
  endtask

  task automatic idle_wait(input int k);
    while (cyc < last_start[k] + frame_len(k) + 2) @(negedge clk_in);
  endtask

  task automatic wait_until_next_edge(input int target);
    while (cyc + 1 < target) @(negedge clk_in);
  endtask

  task automatic do_reset();
    @(posedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rst_tx%0d", k), 32'(txo[k]), 32'd1);
      check_eq($sformatf("rst_busy%0d", k), 32'(bsy[k]), 32'd0);
      check_eq($sformatf("rst_ready%0d", k), 32'(rdy[k]), 32'd1);
      check_eq($sformatf("rst_done%0d", k), 32'(dn[k]), 32'd0);
    end
    clear_model(cyc);
    repeat (2) @(negedge clk_in);
    #1 rst_n = 1'b1;
  endtask

  // Per-cycle comparison of both transmitters against the model.
  always @(negedge clk_in) begin
    if (mon_en && cyc < MAXC) begin
      for (int k = 0; k < 2; k++) begin
        check_eq($sformatf("line%0d", k),  32'(txo[k]), 32'(exp_line[k][cyc]));
        check_eq($sformatf("busy%0d", k),  32'(bsy[k]), 32'(exp_busy[k][cyc]));
        check_eq($sformatf("done%0d", k),  32'(dn[k]),  32'(exp_done[k][cyc]));
        check_eq($sformatf("ready%0d", k), 32'(rdy[k]), 32'(exp_ready[k][cyc]));
      end
    end
  end

  initial begin
    dv = 2'b00; din[0] = 8'h00; din[1] = 8'h00;
    rst_n = 1'b1;
    clear_model(0);
    #1 rst_n = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk_in);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk_in);

    // Single frame 0xA5, and 0x00 on the two-stop-bit instance.
    send(0, 8'hA5);
    send(1, 8'h00);
    idle_wait(0); idle_wait(1);

    // Back-to-back frames, then a strobe while the slot is full (ignored).
    send(0, 8'h3C);
    repeat (10) @(negedge clk_in);
    send(0, 8'hC3);
    send(0, 8'hFF);
    idle_wait(0);

    // Reset in the middle of data bit 3, then a clean 0x55.
    send(0, 8'h96);
    while (cyc < last_start[0] + 4 * CPB + 1) @(negedge clk_in);
    do_reset();
    send(0, 8'h55);
    idle_wait(0);

    // Queue the next byte at edges around the end of the current frame.
    for (int off = -3; off <= 2; off++) begin
      for (int k = 0; k < 2; k++) begin
        idle_wait(k);
        send(k, 8'($urandom));
        wait_until_next_edge(last_start[k] + frame_len(k) + off);
        send(k, 8'($urandom));
      end
    end
    idle_wait(0); idle_wait(1);

    // Random traffic with random gaps; strobes into a full slot are dropped.
    for (int i = 0; i < 120; i++) begin
      if (cyc < MAXC - 300) begin
        repeat ($urandom_range(0, 50)) @(negedge clk_in);
        send($urandom_range(0, 1), 8'($urandom));
      end
    end
    idle_wait(0); idle_wait(1);
    repeat (3) @(negedge clk_in);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
